count_seq_ctrl: RTL and testbench

- Controller that sequences the board's 0..99 up/down counter datapath and owns the record store behind the 7-segment display.
- Accepts one-pulse button events (enable, direction, record, view) and generates the step tick internally from clk.
- Runs the RUN/STOP state machine with a saturating value register.
- Holds a small circular buffer of recorded values; the user browses it with the view button.
- Replaces ad-hoc slow-clock counting: everything runs on the single system clock.

---
 rtl/count_seq_ctrl.sv | 106 ++++++++++
 tb/tb_count_seq_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
// RUN/STOP sequencer for the 0..99 up/down counter with an internal step prescaler
// and a small circular record store browsed by the view button.
module count_seq_ctrl #(
   parameter int UPPER    = 99,
   parameter int LOWER    = 0,
   parameter int TICK_DIV = 33554432,
   parameter int DEPTH    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_pulse,
   input  logic       dir_pulse,
   input  logic       rec_pulse,
   input  logic       view_pulse,
   output logic [7:0] value,
   output logic       dir,
   output logic       running,
   output logic       tick,
   output logic       max,
   output logic       min,
   output logic [7:0] rec_value,
   output logic [1:0] rec_idx,
   output logic [2:0] rec_count,
   output logic       full
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {STOP, RUN} state_t;
   state_t state_q, state_d;

   logic [PW-1:0] presc;
   logic [AW-1:0] wr_ptr, idx, idx_d, rd_ptr;
   logic [CW-1:0] cnt;
   logic [7:0]    mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= STOP;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (en_pulse) state_d = (state_q == STOP) ? RUN : STOP;
   end

   // tick is suppressed when en_pulse lands on the wrap cycle, so it never shows in STOP
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
         dir   <= 1'b1;
         value <= 8'(LOWER);
      end else begin
         if (en_pulse)
            presc <= '0;
         else if (state_q == RUN)
            presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
         tick <= (state_q == RUN) && !en_pulse && (presc == PW'(TICK_DIV - 1));
         if (dir_pulse) dir <= ~dir;
         if (tick) begin
            if (dir) value <= (value == 8'(UPPER)) ? value : value + 8'd1;
            else     value <= (value == 8'(LOWER)) ? value : value - 8'd1;
         end
      end
   end

   always_comb begin
      idx_d = idx;
      if (rec_pulse)
         idx_d = '0;
      else if (view_pulse && cnt != '0)
         idx_d = (CW'(idx) + CW'(1) == cnt) ? '0 : idx + AW'(1);
   end

   // read pointer uses the post-write pointer so a record shows up on the next cycle
   assign rd_ptr = (rec_pulse ? wr_ptr + AW'(1) : wr_ptr) - AW'(1) - idx_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         cnt       <= '0;
         idx       <= '0;
         rec_value <= 8'd0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
      end else begin
         idx <= idx_d;
         if (rec_pulse) begin
            mem[wr_ptr] <= value;
            wr_ptr      <= wr_ptr + AW'(1);
            if (cnt != CW'(DEPTH)) cnt <= cnt + CW'(1);
            rec_value   <= value;
         end else begin
            rec_value <= (cnt == '0) ? 8'd0 : mem[rd_ptr];
         end
      end
   end

   assign running   = (state_q == RUN);
   assign max       = (value == 8'(UPPER)) && dir;
   assign min       = (value == 8'(LOWER)) && !dir;
   assign rec_idx   = 2'(idx);
   assign rec_count = 3'(cnt);
   assign full      = (cnt == CW'(DEPTH));
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a short prescaler: vector table for the
// record/view store plus hand sequences for tick timing, saturation and reset.
module tb_count_seq_ctrl;
   logic       clk = 1'b0, reset = 1'b0;
   logic       en_pulse = 1'b0, dir_pulse = 1'b0, rec_pulse = 1'b0, view_pulse = 1'b0;
   logic [7:0] value, rec_value;
   logic       dir, running, tick, max, min, full;
   logic [1:0] rec_idx;
   logic [2:0] rec_count;

   int ncmp = 0, nfail = 0;

   count_seq_ctrl #(.UPPER(99), .LOWER(0), .TICK_DIV(4), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .en_pulse(en_pulse), .dir_pulse(dir_pulse),
      .rec_pulse(rec_pulse), .view_pulse(view_pulse), .value(value), .dir(dir),
      .running(running), .tick(tick), .max(max), .min(min), .rec_value(rec_value),
      .rec_idx(rec_idx), .rec_count(rec_count), .full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         adv;
      logic       en, dp, rec, view;
      logic [7:0] value;
      logic       dir, running;
      logic [7:0] rec_value;
      logic [1:0] rec_idx;
      logic [2:0] rec_count;
      logic       full;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic e, input logic d, input logic r, input logic v);
      en_pulse = e; dir_pulse = d; rec_pulse = r; view_pulse = v;
      @(posedge clk);
      #1;
      en_pulse = 0; dir_pulse = 0; rec_pulse = 0; view_pulse = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0);
   endtask

   // run from STOP for exactly n steps, then stop again
   task automatic advance(input int n);
      if (n > 0) begin
         cyc(1, 0, 0, 0);
         idle(4 * n);
         cyc(1, 0, 0, 0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1;
      @(posedge clk);
      #1 reset = 0;
   endtask

   vec_t vt [13];
   int   nt;

   initial begin
      vt[0]  = '{0, 0,0,0,1, 8'd0, 1,0, 8'd0, 2'd0, 3'd0, 0};
      vt[1]  = '{5, 0,0,1,0, 8'd5, 1,0, 8'd5, 2'd0, 3'd1, 0};
      vt[2]  = '{1, 0,0,1,0, 8'd6, 1,0, 8'd6, 2'd0, 3'd2, 0};
      vt[3]  = '{1, 0,0,1,0, 8'd7, 1,0, 8'd7, 2'd0, 3'd3, 0};
      vt[4]  = '{1, 0,0,1,0, 8'd8, 1,0, 8'd8, 2'd0, 3'd4, 1};
      vt[5]  = '{1, 0,0,1,0, 8'd9, 1,0, 8'd9, 2'd0, 3'd4, 1};
      vt[6]  = '{0, 0,0,0,1, 8'd9, 1,0, 8'd8, 2'd1, 3'd4, 1};
      vt[7]  = '{0, 0,0,0,1, 8'd9, 1,0, 8'd7, 2'd2, 3'd4, 1};
      vt[8]  = '{0, 0,0,0,1, 8'd9, 1,0, 8'd6, 2'd3, 3'd4, 1};
      vt[9]  = '{0, 0,0,0,1, 8'd9, 1,0, 8'd9, 2'd0, 3'd4, 1};
      vt[10] = '{0, 0,1,0,0, 8'd9, 0,0, 8'd9, 2'd0, 3'd4, 1};
      vt[11] = '{2, 0,0,1,1, 8'd7, 0,0, 8'd7, 2'd0, 3'd4, 1};
      vt[12] = '{0, 0,0,0,1, 8'd7, 0,0, 8'd9, 2'd1, 3'd4, 1};
      nt = 13;

      // reset state, checked while reset is still held
      reset = 1;
      #3;
      chk("rst_value", value, 0);     chk("rst_dir", dir, 1);
      chk("rst_running", running, 0); chk("rst_tick", tick, 0);
      chk("rst_max", max, 0);         chk("rst_min", min, 0);
      chk("rst_rec_value", rec_value, 0);
      chk("rst_rec_count", rec_count, 0); chk("rst_full", full, 0);
      @(posedge clk);
      #1 reset = 0;

      // record / view table
      for (int i = 0; i < nt; i++) begin
         advance(vt[i].adv);
         cyc(vt[i].en, vt[i].dp, vt[i].rec, vt[i].view);
         chk($sformatf("vec%0d_value", i), value, vt[i].value);
         chk($sformatf("vec%0d_dir", i), dir, vt[i].dir);
         chk($sformatf("vec%0d_running", i), running, vt[i].running);
         chk($sformatf("vec%0d_rec_value", i), rec_value, vt[i].rec_value);
         chk($sformatf("vec%0d_rec_idx", i), rec_idx, vt[i].rec_idx);
         chk($sformatf("vec%0d_rec_count", i), rec_count, vt[i].rec_count);
         chk($sformatf("vec%0d_full", i), full, vt[i].full);
      end

      // first tick lands TICK_DIV cycles after entering RUN
      do_reset();
      cyc(1, 0, 0, 0);
      chk("a_running", running, 1); chk("a_tick0", tick, 0);
      idle(3);
      chk("a_tick3", tick, 0);
      idle(1);
      chk("a_tick4", tick, 1); chk("a_value4", value, 0);
      idle(1);
      chk("a_tick5", tick, 0); chk("a_value5", value, 1);
      idle(40);
      chk("a_value45", value, 11); chk("a_running45", running, 1);

      // saturation at UPPER, then turn around
      do_reset();
      advance(98);
      chk("b_value98", value, 98);
      cyc(1, 0, 0, 0);
      idle(9);
      chk("b_value99", value, 99); chk("b_max", max, 1); chk("b_running", running, 1);
      cyc(0, 1, 0, 0);
      chk("b_dir", dir, 0); chk("b_max_off", max, 0);
      idle(3);
      chk("b_value_dn", value, 98);

      // tick and dir_pulse together: step uses the old direction
      do_reset();
      advance(10);
      cyc(1, 0, 0, 0);
      idle(4);
      chk("c_tick", tick, 1);
      cyc(0, 1, 0, 0);
      chk("c_value", value, 11); chk("c_dir", dir, 0);

      // down at LOWER holds; stopping kills further ticks
      begin
         int ticks;
         do_reset();
         cyc(0, 1, 0, 0);
         chk("d_min_stop", min, 1);
         cyc(1, 0, 0, 0);
         ticks = 0;
         for (int i = 0; i < 8; i++) begin
            idle(1);
            if (tick) ticks++;
         end
         chk("d_ticks_run", ticks, 2);
         chk("d_value", value, 0); chk("d_min", min, 1); chk("d_running", running, 1);
         cyc(1, 0, 0, 0);
         chk("d_stopped", running, 0);
         ticks = 0;
         for (int i = 0; i < 8; i++) begin
            idle(1);
            if (tick) ticks++;
         end
         chk("d_ticks_stop", ticks, 0);
         chk("d_value_stop", value, 0);
      end

      // record and view in the same cycle: record wins
      do_reset();
      advance(41);
      cyc(0, 0, 1, 0);
      advance(1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      chk("e_view_idx", rec_idx, 1); chk("e_view_val", rec_value, 41);
      cyc(0, 0, 1, 1);
      chk("e_idx", rec_idx, 0); chk("e_rec_value", rec_value, 42);
      chk("e_rec_count", rec_count, 3);

      // asynchronous reset mid-RUN
      advance(8);
      cyc(1, 0, 0, 0);
      idle(2);
      chk("f_pre_value", value, 50); chk("f_pre_running", running, 1);
      #3 reset = 1;
      #1;
      chk("f_value", value, 0);       chk("f_rec_count", rec_count, 0);
      chk("f_rec_value", rec_value, 0); chk("f_dir", dir, 1);
      chk("f_running", running, 0);   chk("f_tick", tick, 0);
      @(posedge clk);
      #1 reset = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
